// File: rtl/clint_arbiter.sv
// clint_arbiter: round-robin arbiter/sequencer for the single CLINT register port.
// Optional macro CLINT_ARB_LOCK_EN: lock owner keeps the grant across accesses.
module clint_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [XLEN-1:0] m0_data_i,
  input  logic            m0_lock_i,
  output logic [XLEN-1:0] m0_data_o,
  output logic            m0_ready_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [XLEN-1:0] m1_data_i,
  input  logic            m1_lock_i,
  output logic [XLEN-1:0] m1_data_o,
  output logic            m1_ready_o,
  output logic            clint_en_o,
  output logic            clint_we_o,
  output logic [AW-1:0]   clint_addr_o,
  output logic [XLEN-1:0] clint_data_o,
  input  logic [XLEN-1:0] clint_data_i,
  input  logic            clint_ready_i,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e          state_q;
  logic            grant_q;
  logic            last_grant_q;
  logic            en_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] data_q;

  logic            arb_req_d;
  logic            arb_gnt_d;
  logic            sel_we_d;
  logic [AW-1:0]   sel_addr_d;
  logic [XLEN-1:0] sel_data_d;
  logic            done_d;

  assign done_d = (state_q == S_WAIT) & clint_ready_i;

`ifdef CLINT_ARB_LOCK_EN
  logic own_v_q;
  logic own_id_q;
  logic own_lock_d;
  logic done_lock_d;

  assign own_lock_d  = own_id_q ? m1_lock_i : m0_lock_i;
  assign done_lock_d = grant_q ? m1_lock_i : m0_lock_i;

  // Lock owner: set by a locked completion, dropped when seen unlocked in IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      own_v_q  <= 1'b0;
      own_id_q <= 1'b0;
    end else if (done_d) begin
      own_v_q  <= done_lock_d;
      own_id_q <= grant_q;
    end else if (state_q == S_IDLE && own_v_q && !own_lock_d) begin
      own_v_q  <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = m0_lock_i ^ m1_lock_i;
`endif

  // Arbitration: single requester wins, tie goes away from the last grant.
  always_comb begin
    arb_req_d = m0_req_i | m1_req_i;
    arb_gnt_d = (m0_req_i & m1_req_i) ? ~last_grant_q : m1_req_i;
`ifdef CLINT_ARB_LOCK_EN
    if (own_v_q) begin
      arb_req_d = own_id_q ? m1_req_i : m0_req_i;
      arb_gnt_d = own_id_q;
    end
`endif
    sel_we_d   = arb_gnt_d ? m1_we_i   : m0_we_i;
    sel_addr_d = arb_gnt_d ? m1_addr_i : m0_addr_i;
    sel_data_d = arb_gnt_d ? m1_data_i : m0_data_i;
  end

  // Access sequencer: IDLE grants and latches, ISSUE strobes, WAIT completes.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      en_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arb_req_d) begin
            grant_q <= arb_gnt_d;
            en_q    <= 1'b1;
            we_q    <= sel_we_d;
            addr_q  <= sel_addr_d;
            data_q  <= sel_data_d;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          en_q    <= 1'b0;
          we_q    <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (clint_ready_i) begin
            last_grant_q <= grant_q;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign clint_en_o   = en_q;
  assign clint_we_o   = we_q;
  assign clint_addr_o = addr_q;
  assign clint_data_o = data_q;
  assign busy_o       = (state_q != S_IDLE);

  assign m0_ready_o = done_d & ~grant_q;
  assign m1_ready_o = done_d & grant_q;
  assign m0_data_o  = clint_data_i;
  assign m1_data_o  = clint_data_i;

endmodule

// File: tb/tb_clint_arbiter.sv
// tb_clint_arbiter: randomized scoreboard bench for clint_arbiter.
// Drivers push expectations; a monitor pops them on each ready pulse.
module tb_clint_arbiter;

  localparam logic [31:0] MTIME_LO = 32'h1234_5678;

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic m0_req, m0_we, m0_lock, m0_rdy;
  logic m1_req, m1_we, m1_lock, m1_rdy;
  logic [2:0] m0_addr, m1_addr, c_addr;
  logic [31:0] m0_wd, m1_wd, m0_rd, m1_rd;
  logic c_en, c_we, busy;
  logic [31:0] c_wd;
  logic [31:0] c_rd = '0;
  logic c_rdy = 1'b0;

  clint_arbiter #(.XLEN(32), .AW(3)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_data_i(m0_wd), .m0_lock_i(m0_lock),
    .m0_data_o(m0_rd), .m0_ready_o(m0_rdy),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_data_i(m1_wd), .m1_lock_i(m1_lock),
    .m1_data_o(m1_rd), .m1_ready_o(m1_rdy),
    .clint_en_o(c_en), .clint_we_o(c_we), .clint_addr_o(c_addr),
    .clint_data_o(c_wd), .clint_data_i(c_rd), .clint_ready_i(c_rdy),
    .busy_o(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] init_val(input int i);
    return (i == 0) ? MTIME_LO : 32'hA5A5_0000 + 32'(i) * 32'h111;
  endfunction

  // CLINT model: register file with a configurable ready latency.
  logic [31:0] cmem[8];
  int cnt = 0;
  int clint_lat = 1;
  bit loaded = 1'b0;
  always @(posedge clk) begin
    c_rdy <= 1'b0;
    if (!loaded) begin
      for (int i = 0; i < 8; i++) cmem[i] <= init_val(i);
      loaded <= 1'b1;
    end
    if (cnt > 1) cnt <= cnt - 1;
    else if (cnt == 1) begin
      cnt <= 0;
      c_rdy <= 1'b1;
    end
    if (c_en) begin
      c_rd <= cmem[c_addr];
      if (c_we) cmem[c_addr] <= c_wd;
      if (clint_lat == 1) c_rdy <= 1'b1;
      else cnt <= clint_lat - 1;
    end
  end

  task automatic check(input bit ok, input string nm,
                       input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  txn_t q0[$];
  txn_t q1[$];
  int order_q[$];
  int starve[2];
  bit lock_test = 1'b0;
  logic [31:0] ref_mem[8];

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int k, input txn_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic qpop(input int k, output txn_t e);
    if (k == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  function automatic logic get_rdy(input int k);
    return (k == 0) ? m0_rdy : m1_rdy;
  endfunction

  function automatic logic [31:0] get_rd(input int k);
    return (k == 0) ? m0_rd : m1_rd;
  endfunction

  task automatic set_in(input int k, input logic rq, input logic we,
                        input logic [2:0] a, input logic [31:0] d,
                        input logic lk);
    if (k == 0) begin
      m0_req = rq; m0_we = we; m0_addr = a; m0_wd = d; m0_lock = lk;
    end else begin
      m1_req = rq; m1_we = we; m1_addr = a; m1_wd = d; m1_lock = lk;
    end
  endtask

  // Monitor state
  int cyc = 0;
  int en_cyc = 0;
  int en_lat = 1;
  bit prev_en = 1'b0;
  logic cap_we;
  logic [2:0] cap_addr;
  logic [31:0] cap_data;

  task automatic complete(input int k);
    txn_t e;
    int o;
    o = 1 - k;
    check(qsize(k) != 0, "ready_expected", qsize(k), 1);
    if (qsize(k) == 0) return;
    qpop(k, e);
    check(cyc - en_cyc == en_lat, "ready_latency", cyc - en_cyc, en_lat);
    check(cap_we == e.we, "strobe_we", cap_we, e.we);
    check(cap_addr == e.addr, "strobe_addr", cap_addr, e.addr);
    if (e.we) begin
      check(cap_data == e.data, "strobe_data", cap_data, e.data);
      ref_mem[e.addr] = e.data;
    end else begin
      check(get_rd(k) == ref_mem[e.addr], "rdata", get_rd(k),
            ref_mem[e.addr]);
    end
    if (qsize(o) > 0) starve[o]++;
    else starve[o] = 0;
    starve[k] = 0;
    if (!lock_test) check(starve[o] <= 1, "starvation", starve[o], 1);
    order_q.push_back(k);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ref_mem[i] = init_val(i);
    starve[0] = 0;
    starve[1] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_en = 1'b0;
        continue;
      end
      if (c_en) begin
        check(!prev_en, "en_one_cycle", prev_en, 0);
        cap_we = c_we;
        cap_addr = c_addr;
        cap_data = c_wd;
        en_cyc = cyc;
        en_lat = clint_lat;
      end
      if (c_we) check(c_en, "we_only_with_en", c_en, 1);
      prev_en = c_en;
      if (m0_rdy || m1_rdy)
        check(!(m0_rdy && m1_rdy), "one_ready", {m0_rdy, m1_rdy}, 0);
      for (int k = 0; k < 2; k++)
        if (get_rdy(k)) complete(k);
    end
  end

  task automatic do_txn(input int k, input logic we, input logic [2:0] a,
                        input logic [31:0] d, input logic lk,
                        output int lat, output int en_at,
                        output logic [31:0] rd);
    txn_t e;
    e.we = we;
    e.addr = a;
    e.data = d;
    qpush(k, e);
    set_in(k, 1'b1, we, a, d, lk);
    lat = 0;
    en_at = 0;
    rd = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (c_en && en_at == 0) en_at = i;
      if (get_rdy(k)) begin
        lat = i;
        rd = get_rd(k);
        break;
      end
    end
    set_in(k, 1'b0, we, a, d, lk);
    check(lat != 0, "ready_timeout", lat, 1);
    if (lat == 0 && qsize(k) != 0) qpop(k, e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_master(input int k);
    int lat, en_at;
    logic [31:0] rd;
    repeat (25) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_txn(k, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             $urandom, 1'b0, lat, en_at, rd);
    end
  endtask

  int lat, en_at;
  logic [31:0] rd;
  int exp_ord[3];

  initial begin
    set_in(0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    set_in(1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    do_reset();
    check(busy == 1'b0, "rst_busy", busy, 0);
    check(c_en == 1'b0, "rst_en", c_en, 0);
    check(c_we == 1'b0, "rst_we", c_we, 0);
    check(c_addr == 3'd0, "rst_addr", c_addr, 0);
    check(c_wd == 32'd0, "rst_data", c_wd, 0);
    check(m0_rdy == 1'b0, "rst_m0_ready", m0_rdy, 0);
    check(m1_rdy == 1'b0, "rst_m1_ready", m1_rdy, 0);

    do_txn(0, 1'b0, 3'd0, 32'd0, 1'b0, lat, en_at, rd);
    check(en_at == 1, "m0_en_cycle", en_at, 1);
    check(lat == 2, "m0_ready_cycle", lat, 2);
    check(rd == MTIME_LO, "m0_mtime_lo", rd, MTIME_LO);

    do_txn(1, 1'b1, 3'd2, 32'h0000_1000, 1'b0, lat, en_at, rd);
    check(cap_we == 1'b1, "m1_wr_we", cap_we, 1);
    check(cap_addr == 3'd2, "m1_wr_addr", cap_addr, 2);
    check(cap_data == 32'h1000, "m1_wr_data", cap_data, 32'h1000);
    check(lat == 2, "m1_wr_ready", lat, 2);
    do_txn(1, 1'b0, 3'd2, 32'd0, 1'b0, lat, en_at, rd);
    check(rd == 32'h1000, "m1_readback", rd, 32'h1000);

    do_reset();
    order_q.delete();
    fork
      begin
        for (int i = 0; i < 3; i++)
          do_txn(0, 1'b0, 3'(i), 32'd0, 1'b0, lat, en_at, rd);
      end
      begin
        int l2, e2;
        logic [31:0] r2;
        for (int i = 0; i < 3; i++)
          do_txn(1, 1'b0, 3'(i + 3), 32'd0, 1'b0, l2, e2, r2);
      end
    join
    check(order_q.size() == 6, "rr_count", order_q.size(), 6);
    for (int i = 0; i < order_q.size(); i++)
      check(order_q[i] == (i % 2), "rr_order", order_q[i], i % 2);

    clint_lat = 3;
    set_in(0, 1'b1, 1'b0, 3'd1, 32'd0, 1'b0);
    @(negedge clk);
    check(c_en == 1'b1, "rstw_en", c_en, 1);
    @(negedge clk);
    check(busy == 1'b1, "rstw_busy", busy, 1);
    rst_n = 1'b0;
    set_in(0, 1'b0, 1'b0, 3'd1, 32'd0, 1'b0);
    @(negedge clk);
    check(busy == 1'b0, "rstw_idle", busy, 0);
    check(m0_rdy == 1'b0, "rstw_no_ready", m0_rdy, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    clint_lat = 1;
    do_txn(0, 1'b0, 3'd1, 32'd0, 1'b0, lat, en_at, rd);
    check(en_at == 1, "post_rst_en", en_at, 1);
    check(lat == 2, "post_rst_ready", lat, 2);

    do_reset();
    order_q.delete();
    lock_test = 1'b1;
    fork
      begin
        do_txn(0, 1'b1, 3'd2, 32'hAAAA_0001, 1'b1, lat, en_at, rd);
        do_txn(0, 1'b1, 3'd3, 32'hBBBB_0002, 1'b0, lat, en_at, rd);
      end
      begin
        int l2, e2;
        logic [31:0] r2;
        @(negedge clk);
        do_txn(1, 1'b0, 3'd0, 32'd0, 1'b0, l2, e2, r2);
      end
    join
`ifdef CLINT_ARB_LOCK_EN
    exp_ord = '{0, 0, 1};
`else
    exp_ord = '{0, 1, 0};
`endif
    check(order_q.size() == 3, "lock_count", order_q.size(), 3);
    for (int i = 0; i < order_q.size() && i < 3; i++)
      check(order_q[i] == exp_ord[i], "lock_order", order_q[i], exp_ord[i]);
    lock_test = 1'b0;
    repeat (2) @(negedge clk);

    fork
      rand_master(0);
      rand_master(1);
    join
    repeat (4) @(negedge clk);
    check(q0.size() + q1.size() == 0, "queues_drained",
          q0.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
